// File: rtl/r512_pkg.sv
// rtl/r512_pkg.sv - shared types and defaults for the r512 sequencing controller (watchdog limit used with R512_TIMEOUT_EN)
package r512_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 16;

  // Word counter covers both the load and the unload phase.
  localparam int CNT_W = 5;

  // WAIT watchdog: 16-bit counter; expiry on its terminal count gives 65536 WAIT cycles.
  localparam int                WDOG_W     = 16;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } state_t;

endpackage

// File: rtl/r512_word_shifter.sv
// rtl/r512_word_shifter.sv - wide register with parallel load and word-wide right shift entering at the MSB end
module r512_word_shifter #(
  parameter int WIDTH   = 512,
  parameter int SHIFT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               shift,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic [WIDTH-1:0]   data
);

  // Parallel load wins over shift; shifting drops the low word and inserts shift_in at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {shift_in, data[WIDTH-1:SHIFT_W]};
    end
  end

endmodule

// File: rtl/r512_seq_ctrl.sv
// rtl/r512_seq_ctrl.sv - streams two operands into the r512 core, starts it, and streams the result back (optional WAIT watchdog via R512_TIMEOUT_EN)
module r512_seq_ctrl
  import r512_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           q_word,
  input  logic [WORD_W-1:0]           p_word,
  output logic [WORD_W*NUM_WORDS-1:0] core_q,
  output logic [WORD_W*NUM_WORDS-1:0] core_p,
  output logic                        core_start,
  input  logic                        core_done,
  input  logic [WORD_W*NUM_WORDS-1:0] core_m,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           m_word,
  output logic                        out_last,
  output logic                        busy
`ifdef R512_TIMEOUT_EN
  ,
  output logic                        timeout
`endif
);

  localparam int               OP_W     = WORD_W * NUM_WORDS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             out_fire;
  logic             last_word;
  logic             capture;
  logic             wdog_expire;
  logic [OP_W-1:0]  res;
  logic             unused_res_hi;

  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (cnt == LAST_IDX);
  // core_done only matters while waiting on the core.
  assign capture   = (state == WAIT) && core_done;
  assign m_word    = res[WORD_W-1:0];
  // Upper result words reach m_word only by shifting down.
  assign unused_res_hi = ^res[OP_W-1:WORD_W];

`ifdef R512_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog;

  assign wdog_expire = (state == WAIT) && !core_done && (wdog == WDOG_LIMIT);
  assign timeout     = wdog_expire;

  // Count consecutive WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (state == WAIT) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: load NUM_WORDS pairs, pulse start, wait for the core, drain the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_word ? START : LOAD;
      LOAD:    if (accept && last_word) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (core_done) begin
          state_nxt = UNLOAD;
        end else if (wdog_expire) begin
          state_nxt = IDLE;
        end
      end
      UNLOAD:  if (out_fire && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    in_ready   = (state == IDLE) || (state == LOAD);
    core_start = (state == START);
    out_valid  = (state == UNLOAD);
    out_last   = (state == UNLOAD) && last_word;
    busy       = (state != IDLE);
  end

  // One counter serves load and unload: it wraps to zero on the last word of either phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept || out_fire) begin
      cnt <= last_word ? '0 : cnt + 1'b1;
    end
  end

  r512_word_shifter #(.WIDTH(OP_W), .SHIFT_W(WORD_W)) u_q_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ({OP_W{1'b0}}),
    .shift     (accept),
    .shift_in  (q_word),
    .data      (core_q)
  );

  r512_word_shifter #(.WIDTH(OP_W), .SHIFT_W(WORD_W)) u_p_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ({OP_W{1'b0}}),
    .shift     (accept),
    .shift_in  (p_word),
    .data      (core_p)
  );

  r512_word_shifter #(.WIDTH(OP_W), .SHIFT_W(WORD_W)) u_res_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture),
    .load_data (core_m),
    .shift     (out_fire),
    .shift_in  ({WORD_W{1'b0}}),
    .data      (res)
  );

endmodule

// File: tb/tb_r512_seq_ctrl.sv
// tb/tb_r512_seq_ctrl.sv - randomized self-checking bench for r512_seq_ctrl against a transaction-level model
module tb_r512_seq_ctrl;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int OW = W * N;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          core_done = 1'b0;
  logic [W-1:0]  q_word    = '0;
  logic [W-1:0]  p_word    = '0;
  logic [OW-1:0] core_m    = '0;
  wire           in_ready, core_start, out_valid, out_last, busy;
  wire  [W-1:0]  m_word;
  wire  [OW-1:0] core_q, core_p;
`ifdef R512_TIMEOUT_EN
  wire           timeout;
`endif

  always #5 clk = ~clk;

  r512_seq_ctrl #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q_word     (q_word),
    .p_word     (p_word),
    .core_q     (core_q),
    .core_p     (core_p),
    .core_start (core_start),
    .core_done  (core_done),
    .core_m     (core_m),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .m_word     (m_word),
    .out_last   (out_last),
    .busy       (busy)
`ifdef R512_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    total++;
    $display("FAIL %s: got no completion expected completion within cycle bound", nm);
  endtask

  function automatic logic [OW-1:0] rand_wide();
    logic [OW-1:0] r;
    for (int i = 0; i < N; i++) r[W*i +: W] = $urandom;
    return r;
  endfunction

  // ---------------- transaction-level reference model ----------------
  // ph: 0 taking words, 1 start cycle, 2 waiting on core, 3 returning result
  int            ph = 0, n_in = 0, n_out = 0, wcyc = 0;
  bit            regs_zero = 1'b1;
  logic [W-1:0]  qa[N], pa[N];
  logic [OW-1:0] e_q = '0, e_p = '0, e_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; n_in = 0; n_out = 0; wcyc = 0; regs_zero = 1'b1;
      e_q = '0; e_p = '0; e_res = '0;
    end else begin
      case (ph)
        0: if (in_valid) begin
          qa[n_in] = q_word;
          pa[n_in] = p_word;
          n_in++;
          regs_zero = 1'b0;
          if (n_in == N) begin
            e_q = '0; e_p = '0;
            for (int i = 0; i < N; i++) begin
              e_q |= OW'(qa[i]) << (W * i);
              e_p |= OW'(pa[i]) << (W * i);
            end
            ph = 1;
          end
        end
        1: begin ph = 2; wcyc = 0; end
        2: if (core_done) begin
          e_res = core_m; n_out = 0; ph = 3;
        end else begin
          wcyc++;
`ifdef R512_TIMEOUT_EN
          if (wcyc == 65536) begin ph = 0; n_in = 0; end
`endif
        end
        3: if (out_ready) begin
          n_out++;
          if (n_out == N) begin ph = 0; n_in = 0; end
        end
        default: ph = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        chk("rst_busy",       busy,       0);
        chk("rst_core_start", core_start, 0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_last",   out_last,   0);
        chk("rst_core_q",     core_q,     0);
        chk("rst_core_p",     core_p,     0);
      end else begin
        chk("in_ready",   in_ready,   ph == 0);
        chk("busy",       busy,       (ph != 0) || (n_in != 0));
        chk("core_start", core_start, ph == 1);
        chk("out_valid",  out_valid,  ph == 3);
        if (ph == 3) begin
          chk("m_word",   m_word,   e_res[W*n_out +: W]);
          chk("out_last", out_last, n_out == N - 1);
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        if (ph != 0) begin
          chk("core_q", core_q, e_q);
          chk("core_p", core_p, e_p);
        end else if (regs_zero) begin
          chk("core_q_zero", core_q, 0);
          chk("core_p_zero", core_p, 0);
        end
`ifdef R512_TIMEOUT_EN
        chk("timeout", timeout, (ph == 2) && (wcyc == 65535) && !core_done);
`endif
      end
    end
  end

  // ---------------- core stand-in: done after core_lat cycles, noise otherwise ----------------
  int            pend     = 0;
  int            core_lat = 20;
  bit            noise_en = 1'b0;
  logic [OW-1:0] core_val = '0;

  always @(negedge clk) begin : core_proc
    bit fire;
    fire = 1'b0;
    if (!rst_n) pend = 0;
    if (pend > 0) begin
      pend--;
      fire = (pend == 0);
    end
    if (core_start && core_lat > 0) pend = core_lat;
    if (fire) begin
      core_done = 1'b1;
      core_m    = core_val;
    end else begin
      core_done = noise_en;
      core_m    = rand_wide();
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] sq[N], sp[N];
  logic [W-1:0] got_w[$];
  bit           got_l[$];

  task automatic send(input logic [W-1:0] q, input logic [W-1:0] p);
    bit rdy;
    int b;
    in_valid = 1'b1; q_word = q; p_word = p;
    for (b = 0; b < 200; b++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    if (b == 200) bound_fail("send");
    in_valid = 1'b0; q_word = $urandom; p_word = $urandom;
  endtask

  task automatic load(input int gap_max);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send(sq[i], sp[i]);
    end
  endtask

  // mode 0: always ready, 1: toggling ready, 2: random ready
  task automatic unload(input int mode);
    bit done, tog, ov, ol;
    logic [W-1:0] mw;
    int cyc;
    done = 1'b0; tog = 1'b1; cyc = 0;
    got_w.delete(); got_l.delete();
    while (!done && cyc < 2000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      @(negedge clk); ov = out_valid; ol = out_last; mw = m_word;
      @(posedge clk); #1; cyc++;
      if (ov && out_ready) begin
        got_w.push_back(mw);
        got_l.push_back(ol);
        if (ol) done = 1'b1;
      end
    end
    out_ready = 1'b0;
    if (!done) bound_fail("unload");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1; chk_en = 1'b1;
    @(negedge clk);
    chk("lit_reset_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("lit_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Directed: words 1..16, core answers 0xA0000000+i after 20 cycles, ready toggling.
    for (int i = 0; i < N; i++) begin
      sq[i] = W'(i + 1);
      sp[i] = W'(32'h100 + i + 1);
      core_val[W*i +: W] = W'(32'hA000_0000 + i);
    end
    core_lat = 20;
    load(0);
    @(negedge clk);
    chk("lit_start_pulse", core_start, 1);
    chk("lit_core_q_lo", core_q[31:0], 32'h1);
    chk("lit_core_q_hi", core_q[511:480], 32'h10);
    chk("lit_core_p_lo", core_p[31:0], 32'h101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_start_one_cycle", core_start, 0);
    @(posedge clk); #1;
    unload(1);
    chk("lit_word_count", got_w.size(), N);
    for (int i = 0; i < N && i < got_w.size(); i++) begin
      chk("lit_m_word", got_w[i], 32'hA000_0000 + i);
      chk("lit_out_last", got_l[i], i == N - 1);
    end

    // core_done held high through the load is ignored; only the WAIT value is captured.
    for (int i = 0; i < N; i++) begin sq[i] = $urandom; sp[i] = $urandom; end
    core_val = rand_wide();
    core_lat = 7;
    noise_en = 1'b1;
    load(3);
    noise_en = 1'b0;
    unload(0);
    if (got_w.size() > 0) chk("lit_capture_in_wait", got_w[0], core_val[31:0]);
    else bound_fail("capture_in_wait");

    // Reset after 7 words, then a clean full load.
    for (int i = 0; i < 7; i++) send($urandom, $urandom);
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midload_busy", busy, 0);
    chk("lit_midload_q", core_q, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin sq[i] = W'(i + 1); sp[i] = W'(32'hF0 + i); end
    core_val = rand_wide();
    core_lat = 3;
    load(2);
    @(negedge clk);
    chk("lit_reload_q_lo", core_q[31:0], 32'h1);
    chk("lit_reload_q_mid", core_q[255:224], 32'h8);
    chk("lit_reload_q_hi", core_q[511:480], 32'h10);
    @(posedge clk); #1;
    unload(2);

    // Randomized operations.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin sq[i] = $urandom; sp[i] = $urandom; end
      core_val = rand_wide();
      core_lat = $urandom_range(1, 30);
      noise_en = 1'($urandom_range(0, 1));
      load($urandom_range(0, 4));
      noise_en = 1'b0;
      unload($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

`ifdef R512_TIMEOUT_EN
    begin
      int k;
      bit seen;
      for (int i = 0; i < N; i++) begin sq[i] = $urandom; sp[i] = $urandom; end
      core_lat = 0;
      load(0);
      k = 0; seen = 1'b0;
      while (!seen && k < 70000) begin
        @(negedge clk);
        if (timeout) seen = 1'b1;
        else k++;
      end
      if (seen) chk("lit_timeout_cycle", k, 65536);
      else bound_fail("timeout");
      @(posedge clk); #1;
      @(negedge clk);
      chk("lit_timeout_idle", busy, 0);
      core_lat = 20;
    end
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/r512_seq_ctrl.md
R512_SEQ_CTRL -- requirements
Module: r512_seq_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the streaming word width in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 16, meaning words per operand; operand width is WORD_W*NUM_WORDS (512).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  q_word/p_word pair valid.
REQ-006 SHALL have port in_ready  output  1  controller accepts an operand word pair.
REQ-007 SHALL have ports q_word, p_word  input  WORD_W  operand words, least-significant word first.
REQ-008 SHALL have ports core_q, core_p  output  512  assembled operands driven to the r512 core.
REQ-009 SHALL have port core_start  output  1  one-cycle start pulse to the core.
REQ-010 SHALL have port core_done  input  1  core result valid.
REQ-011 SHALL have port core_m  input  512  core result.
REQ-012 SHALL have ports out_valid/out_ready  output/input  1  result word handshake.
REQ-013 SHALL have port m_word  output  WORD_W  result word, least-significant word first.
REQ-014 SHALL have port out_last  output  1  marks final result word.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, START, WAIT, UNLOAD.
REQ-017 SHALL assert in_ready only in IDLE and LOAD; a word is accepted on in_valid&&in_ready.
REQ-018 SHALL shift each accepted word into the MSB end of the operand registers ({word, reg[511:32]}), so that after 16 words the first word occupies bits 31:0.
REQ-019 SHALL use a 5-bit word counter incremented per accepted word; IDLE->LOAD on the first accept; LOAD->START on accept of word 16 (NUM_WORDS).
REQ-020 SHALL assert core_start for exactly one cycle in START, then enter WAIT.
REQ-021 SHALL hold core_q/core_p stable from START until the next LOAD.
REQ-022 SHALL sample core_done only in WAIT; core_done in any other state is ignored.
REQ-023 SHALL capture core_m into a 512-bit result register on the WAIT cycle where core_done=1, then enter UNLOAD.
REQ-024 SHALL present result bits 31:0 first in UNLOAD, shift right by WORD_W per out_valid&&out_ready, and assert out_last with word 16.
REQ-025 SHALL hold m_word/out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL return to IDLE on the handshake of the last word; the same cycle SHALL NOT accept input.
REQ-027 SHALL keep in_valid gaps in LOAD without losing counter or data state.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-LOAD, WAIT or UNLOAD, force IDLE; clear counter, operand and result registers to 0; drive core_start, out_valid, out_last and busy to 0; drive in_ready to 1 after release.

Configuration
REQ-029 SHALL, with R512_TIMEOUT_EN defined, add a 16-bit WAIT watchdog plus output timeout (1 bit); after 65536 WAIT cycles without core_done, pulse timeout for one cycle and return to IDLE.
REQ-030 SHALL, without R512_TIMEOUT_EN, omit the watchdog and timeout port; WAIT persists until core_done.

Structure
REQ-031 SHALL place the FSM state enum, WORD_W/NUM_WORDS defaults and the timeout limit in shared package r512_pkg.
REQ-032 SHALL use one sub-module, r512_word_shifter (512-bit shift register with load/shift enable), instanced three times: q, p, result.

Verification
REQ-033 Load words 0x00000001..0x00000010 with continuous in_valid -> core_q[31:0]=0x1, core_q[511:480]=0x10; core_start pulses 1 cycle after the 16th accept.
REQ-034 Core model returns core_m with word i = 0xA0000000+i after 20 cycles -> m_word sequence 0xA0000000..0xA000000F; out_last only on the 16th word.
REQ-035 out_ready toggles 1/0 each cycle during UNLOAD -> no word repeated or dropped; m_word stable during stalls.
REQ-036 core_done held high during LOAD -> ignored; result captured only in WAIT.
REQ-037 rst_n low after 7 words loaded -> IDLE, busy=0; next full 16-word load produces correct core_q.
REQ-038 With R512_TIMEOUT_EN: core_done never asserted -> timeout pulses at WAIT cycle 65536, FSM returns to IDLE.
